// File: rtl/logic_cmd_driver_pkg.sv
// rtl/logic_cmd_driver_pkg.sv - shared opcodes and FSM state type for the logic command driver
package logic_cmd_driver_pkg;

  // Opcode encoding shared by the command driver and the logic unit
  localparam logic [1:0] OP_AND     = 2'b00;
  localparam logic [1:0] OP_OR      = 2'b01;
  localparam logic [1:0] OP_NOT     = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  // Command sequencing states
  typedef enum logic [2:0] {
    ST_HDR  = 3'd0,
    ST_OPA  = 3'd1,
    ST_OPB  = 3'd2,
    ST_EXEC = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  // Only the three defined operations are accepted from a header
  function automatic logic op_is_legal(input logic [1:0] op);
    return (op != OP_ILLEGAL);
  endfunction

  // NOT takes a single operand, so its command skips operand B
  function automatic logic op_is_unary(input logic [1:0] op);
    return (op == OP_NOT);
  endfunction

endpackage

// File: rtl/logic_cmd_driver_alu.sv
// rtl/logic_cmd_driver_alu.sv - combinational and/or/not logic unit driven by logic_cmd_driver
module logic_cmd_driver_alu
  import logic_cmd_driver_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [1:0] ctrl,
  output logic [7:0] s
);

  // Select the bitwise operation; the unused encoding yields zero
  always_comb begin
    s = 8'h00;
    case (ctrl)
      OP_AND:  s = a & b;
      OP_OR:   s = a | b;
      OP_NOT:  s = ~a;
      default: s = 8'h00;
    endcase
  end

endmodule

// File: rtl/logic_cmd_driver.sv
// rtl/logic_cmd_driver.sv - byte-stream command sequencer driving an external and/or/not logic unit
module logic_cmd_driver
  import logic_cmd_driver_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
)
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [1:0] alu_ctrl,
  input  logic [7:0] alu_s,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       err
);

  // EXEC lasts SETTLE_CYCLES cycles: the counter is loaded with one less and exits at zero
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [3:0] settle_cnt;

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // Command FSM; every output is registered so in_ready/out_valid/err never glitch.
  // alu_ctrl doubles as the latched opcode: it is zero outside a command and holds
  // the header op from the cycle after acceptance until the result is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_HDR;
      settle_cnt <= 4'd0;
      alu_a      <= 8'h00;
      alu_b      <= 8'h00;
      alu_ctrl   <= OP_AND;
      out_data   <= 8'h00;
      out_valid  <= 1'b0;
      err        <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      err <= 1'b0;
      case (state)
        ST_HDR: begin
          if (in_xfer) begin
            if (op_is_legal(in_data[1:0])) begin
              alu_ctrl <= in_data[1:0];
              state    <= ST_OPA;
            end else begin
              // Illegal header is dropped without touching the operands
              err <= 1'b1;
            end
          end
        end

        ST_OPA: begin
          if (in_xfer) begin
            alu_a <= in_data;
            if (op_is_unary(alu_ctrl)) begin
              alu_b      <= 8'h00;
              settle_cnt <= SETTLE_LOAD;
              in_ready   <= 1'b0;
              state      <= ST_EXEC;
            end else begin
              state <= ST_OPB;
            end
          end
        end

        ST_OPB: begin
          if (in_xfer) begin
            alu_b      <= in_data;
            settle_cnt <= SETTLE_LOAD;
            in_ready   <= 1'b0;
            state      <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          if (settle_cnt == 4'd0) begin
            out_data  <= alu_s;
            out_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end

        ST_RESP: begin
          if (out_xfer) begin
            out_valid <= 1'b0;
            alu_ctrl  <= OP_AND;
            in_ready  <= 1'b1;
            state     <= ST_HDR;
          end
        end

        default: begin
          out_valid <= 1'b0;
          alu_ctrl  <= OP_AND;
          in_ready  <= 1'b1;
          state     <= ST_HDR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_cmd_driver.sv
// tb/tb_logic_cmd_driver.sv - self-checking bench for logic_cmd_driver with default and 4-cycle settle
module tb_logic_cmd_driver;
  import logic_cmd_driver_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;
  logic       sel;

  logic       in_ready1, out_valid1, err1;
  logic [7:0] a1, b1, s1, od1;
  logic [1:0] c1;
  logic       in_ready4, out_valid4, err4;
  logic [7:0] a4, b4, s4, od4;
  logic [1:0] c4;

  logic_cmd_driver #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
    .alu_a(a1), .alu_b(b1), .alu_ctrl(c1), .alu_s(s1),
    .out_valid(out_valid1), .out_data(od1), .out_ready(out_ready), .err(err1)
  );
  logic_cmd_driver_alu u_alu1 (.a(a1), .b(b1), .ctrl(c1), .s(s1));

  logic_cmd_driver #(.SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready4),
    .alu_a(a4), .alu_b(b4), .alu_ctrl(c4), .alu_s(s4),
    .out_valid(out_valid4), .out_data(od4), .out_ready(out_ready), .err(err4)
  );
  logic_cmd_driver_alu u_alu4 (.a(a4), .b(b4), .ctrl(c4), .s(s4));

  logic       o_in_ready, o_out_valid, o_err;
  logic [7:0] o_a, o_b, o_data;
  logic [1:0] o_ctrl;
  assign o_in_ready  = sel ? in_ready4  : in_ready1;
  assign o_out_valid = sel ? out_valid4 : out_valid1;
  assign o_err       = sel ? err4       : err1;
  assign o_a         = sel ? a4         : a1;
  assign o_b         = sel ? b4         : b1;
  assign o_ctrl      = sel ? c4         : c1;
  assign o_data      = sel ? od4        : od1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int last_xfer = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model(input int op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      0:       return a & b;
      1:       return a | b;
      default: return ~a;
    endcase
  endfunction

  // Called and returns at posedge+1; records the cycle in which the byte transfers
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    while (!o_in_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("send_timeout", 32'(o_in_ready), 32'd1);
    last_xfer = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  // Returns at the negedge where out_valid is first seen high
  task automatic wait_result(output logic [7:0] d, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!o_out_valid && n < 100) begin @(negedge clk); n++; end
    check("out_valid_rise", 32'(o_out_valid), 32'd1);
    check("in_ready_in_resp", 32'(o_in_ready), 32'd0);
    check("err_with_valid", 32'(o_err), 32'd0);
    d   = o_data;
    lat = cyc - last_xfer;
  endtask

  task automatic run_cmd(input int op, input logic [7:0] a, input logic [7:0] b,
                         input logic [5:0] hi, input int gap, output logic [7:0] d);
    int lat;
    send_byte({hi, 2'(op)}, gap);
    send_byte(a, gap);
    if (op != 2) send_byte(b, gap);
    wait_result(d, lat);
    check("result", 32'(d), 32'(model(op, a, b)));
    check("latency", 32'(lat), sel ? 32'd5 : 32'd2);
    check("alu_ctrl_held", 32'(o_ctrl), 32'(op));
    check("alu_a_held", 32'(o_a), 32'(a));
    check("alu_b_held", 32'(o_b), (op == 2) ? 32'd0 : 32'(b));
    @(negedge clk);
    check("out_valid_drop", 32'(o_out_valid), 32'd0);
    check("in_ready_back", 32'(o_in_ready), 32'd1);
    check("alu_ctrl_idle", 32'(o_ctrl), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic illegal_hdr(input logic [5:0] hi, input logic [7:0] prev_a, input logic [7:0] prev_b);
    send_byte({hi, 2'b11}, 0);
    @(negedge clk);
    check("err_pulse", 32'(o_err), 32'd1);
    check("err_no_valid", 32'(o_out_valid), 32'd0);
    check("err_keeps_a", 32'(o_a), 32'(prev_a));
    check("err_keeps_b", 32'(o_b), 32'(prev_b));
    check("err_ctrl", 32'(o_ctrl), 32'd0);
    @(negedge clk);
    check("err_once", 32'(o_err), 32'd0);
    check("err_stays_hdr", 32'(o_in_ready), 32'd1);
    check("err_no_valid2", 32'(o_out_valid), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] d, ra, rb, la, lb;
    int lat, op, gap;

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1; sel = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(o_in_ready), 32'd1);
    check("rst_out_valid", 32'(o_out_valid), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    check("rst_alu_a", 32'(o_a), 32'd0);
    check("rst_alu_b", 32'(o_b), 32'd0);
    check("rst_alu_ctrl", 32'(o_ctrl), 32'd0);
    check("rst_out_data", 32'(o_data), 32'd0);
    @(posedge clk); #1;

    // AND 0xF0 & 0x3C
    run_cmd(0, 8'hF0, 8'h3C, 6'h00, 0, d);
    check("and_value", 32'(d), 32'h30);

    // NOT 0x5A, next byte must be a fresh header
    run_cmd(2, 8'h5A, 8'h00, 6'h00, 0, d);
    check("not_value", 32'(d), 32'hA5);
    run_cmd(0, 8'h55, 8'h0F, 6'h00, 0, d);

    // Illegal header, then OR
    illegal_hdr(6'h00, 8'h55, 8'h0F);
    run_cmd(1, 8'h0F, 8'hA0, 6'h00, 0, d);
    check("or_value", 32'(d), 32'hAF);

    // Backpressure on OR 0x81 | 0x18
    out_ready = 1'b0;
    send_byte(8'h01, 0);
    send_byte(8'h81, 0);
    send_byte(8'h18, 0);
    wait_result(d, lat);
    check("bp_latency", 32'(lat), 32'd2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid_hold", 32'(o_out_valid), 32'd1);
      check("bp_data_hold", 32'(o_data), 32'h99);
      check("bp_in_ready", 32'(o_in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release", 32'(o_out_valid), 32'd0);
    check("bp_in_ready_back", 32'(o_in_ready), 32'd1);
    @(posedge clk); #1;

    // Reset after header 0x01 and A = 0xFF
    send_byte(8'h01, 0);
    send_byte(8'hFF, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_alu_a", 32'(o_a), 32'd0);
    check("mid_rst_alu_b", 32'(o_b), 32'd0);
    check("mid_rst_ctrl", 32'(o_ctrl), 32'd0);
    check("mid_rst_data", 32'(o_data), 32'd0);
    check("mid_rst_in_ready", 32'(o_in_ready), 32'd1);
    check("mid_rst_err", 32'(o_err), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_rst_no_valid", 32'(o_out_valid), 32'd0);
    end
    @(posedge clk); #1;
    run_cmd(0, 8'hFF, 8'h0F, 6'h00, 0, d);
    check("post_rst_and", 32'(d), 32'h0F);

    // SETTLE_CYCLES = 4 with random commands and input gaps
    sel = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    la = 8'h00; lb = 8'h00;
    for (int k = 0; k < 16; k++) begin
      op  = int'($urandom_range(0, 3));
      gap = int'($urandom_range(0, 3));
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      if (op == 3) begin
        illegal_hdr(6'($urandom), la, lb);
      end else begin
        run_cmd(op, ra, rb, 6'($urandom), gap, d);
        la = ra;
        lb = (op == 2) ? 8'h00 : rb;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/logic_cmd_driver.md
LOGIC_CMD_DRIVER -- requirements
Module: logic_cmd_driver

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1, cycles the ALU outputs are held stable before result capture; legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  command byte present on in_data.
REQ-005 in_data  input  8  command byte stream (header, operand A, operand B).
REQ-006 in_ready  output  1  block accepts in_data this cycle; a byte transfers when in_valid && in_ready.
REQ-007 alu_a  output  8  operand A driven to the logic unit.
REQ-008 alu_b  output  8  operand B driven to the logic unit.
REQ-009 alu_ctrl  output  2  op select to the logic unit: 00 and, 01 or, 10 not a.
REQ-010 alu_s  input  8  combinational result from the logic unit.
REQ-011 out_valid  output  1  result byte valid on out_data.
REQ-012 out_data  output  8  captured result.
REQ-013 out_ready  input  1  consumer accepts; a result transfers when out_valid && out_ready.
REQ-014 err  output  1  one-cycle pulse on illegal opcode.

Function
REQ-015 FSM states: HDR, OPA, OPB, EXEC, RESP; encoding is free.
REQ-016 in_ready SHALL be 1 in HDR, OPA and OPB, and 0 in EXEC and RESP.
REQ-017 HDR: on transfer, header bits[1:0] are latched as op and bits[7:2] are ignored; op 00/01/10 moves to OPA, op 11 stays in HDR and pulses err for the next cycle.
REQ-018 OPA: on transfer, latch the byte into alu_a; op 10 moves to EXEC, otherwise to OPB.
REQ-019 OPB: on transfer, latch the byte into alu_b, then move to EXEC; for op 10, alu_b holds 0x00.
REQ-020 alu_ctrl SHALL equal the latched op from the cycle after header acceptance until return to HDR, and 00 otherwise.
REQ-021 alu_a, alu_b and alu_ctrl SHALL remain stable throughout EXEC and RESP.
REQ-022 EXEC lasts exactly SETTLE_CYCLES cycles, counted by a 4-bit down-counter; on the last cycle, alu_s is registered into out_data and the FSM moves to RESP.
REQ-023 Latency: out_valid rises SETTLE_CYCLES+1 cycles after the final operand transfer edge (2 cycles at default).
REQ-024 RESP: out_valid = 1 and out_data holds; on transfer, the FSM returns to HDR with out_valid = 0 the next cycle.
REQ-025 Backpressure: out_ready low SHALL hold out_valid and out_data indefinitely; no input byte is accepted meanwhile.
REQ-026 in_valid low in HDR, OPA or OPB SHALL stall in place with no state or data change.
REQ-027 Only one command is in flight at a time; the next header is accepted no earlier than the cycle after the result transfer.
REQ-028 err SHALL never coincide with out_valid, and an illegal header SHALL NOT alter alu_a or alu_b.

Reset
REQ-029 With rst high at a clock edge: state = HDR, counter = 0, alu_a = alu_b = out_data = 0x00, alu_ctrl = 00, out_valid = 0, err = 0, in_ready = 1 in the following cycle.
REQ-030 rst asserted mid-command (any state) SHALL discard the partial command and any pending result without emitting out_valid.

Structure
REQ-031 A shared package holds the opcode constants (OP_AND = 2'b00, OP_OR = 2'b01, OP_NOT = 2'b10, OP_ILLEGAL = 2'b11) and the FSM state type; the logic unit uses the same opcode constants.
REQ-032 This block contains no sub-module; the bench instantiates the existing and/or/not logic unit alongside it, wiring alu_a/alu_b/alu_ctrl to its a/b/ctrl inputs and its s output to alu_s.

Verification
REQ-033 AND: bytes 0x00, 0xF0, 0x3C with out_ready = 1 -> out_data = 0x30, out_valid for 1 cycle, 2 cycles after the 0x3C transfer.
REQ-034 NOT: bytes 0x02, 0x5A -> only 2 bytes consumed, out_data = 0xA5, alu_b = 0x00; the following byte is treated as a new header.
REQ-035 Illegal: header 0x03 -> err pulses once, state remains HDR, no out_valid; a subsequent OR 0x0F|0xA0 -> 0xAF.
REQ-036 Backpressure: OR 0x81|0x18 with out_ready = 0 for 10 cycles -> out_valid = 1 and out_data = 0x99 stable throughout, in_ready = 0; transfer on the first out_ready = 1.
REQ-037 Reset mid-op: rst after header 0x01 and A = 0xFF -> all outputs at reset values; the next command AND 0xFF & 0x0F -> 0x0F.
REQ-038 SETTLE_CYCLES = 4, random in_valid gaps: all results match the a/b/ctrl model and latency = 5 cycles.
